// File: rtl/m10k_source_loader.sv
// Streams one frame of upstream samples into the source M10K, then holds START
// until the compute stage reports the frame consumed.
module m10k_source_loader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_go,
  input  logic [ADDR_W:0]   frame_len,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] M10K_write_data_source,
  output logic [ADDR_W-1:0] M10K_write_address_source,
  output logic              M10K_write_source,
  output logic              START,
  input  logic              compute_done,
  output logic [ADDR_W:0]   loaded_count,
  output logic              busy
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_RUN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_inc;
  logic [CNT_W-1:0]    w_len_clamped;
  logic                w_go_ok;
  logic                w_accept;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_start;
  logic                r_busy;

  assign w_count_inc   = r_count + CNT_W'(1);
  assign w_len_clamped = (frame_len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : frame_len;
  assign w_go_ok       = (r_state == S_IDLE) && load_go && (frame_len != '0);
  assign w_accept      = (r_state == S_LOAD) && in_valid;

  // Next-state decode; requests outside their owning state fall through untouched.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_go_ok) w_state_nxt = S_LOAD;
      S_LOAD:  if (w_accept && (w_count_inc == r_len)) w_state_nxt = S_FLUSH;
      S_FLUSH: w_state_nxt = S_RUN;
      S_RUN:   if (compute_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Write port trails the accepting edge by one cycle; address/data hold between beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len     <= '0;
      r_count   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_wr_en <= w_accept;
      r_start <= (w_state_nxt == S_RUN);
      r_busy  <= (w_state_nxt != S_IDLE);
      if (w_go_ok) begin
        r_len     <= w_len_clamped;
        r_count   <= '0;
        r_wr_addr <= '0;
      end
      if (w_accept) begin
        r_wr_addr <= r_count[ADDR_W-1:0];
        r_wr_data <= in_data;
        r_count   <= w_count_inc;
      end
    end
  end

  assign in_ready                  = (r_state == S_LOAD);
  assign M10K_write_source         = r_wr_en;
  assign M10K_write_address_source = r_wr_addr;
  assign M10K_write_data_source    = r_wr_data;
  assign START                     = r_start;
  assign busy                      = r_busy;
  assign loaded_count              = r_count;

endmodule

// File: tb/tb_m10k_source_loader.sv
// Directed bench for m10k_source_loader: cycle table plus multi-cycle frame sequences
// against a behavioural model of the source M10K.
module tb_m10k_source_loader;

  logic       clk;
  logic       reset;
  logic       load_go;
  logic [8:0] frame_len;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] wr_data;
  logic [7:0] wr_addr;
  logic       wr_en;
  logic       start;
  logic       compute_done;
  logic [8:0] loaded_count;
  logic       busy;

  int checks;
  int failures;
  int start_rises;
  logic start_q;
  logic tb_fill;
  logic [7:0] mem [256];

  m10k_source_loader #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .load_go                   (load_go),
    .frame_len                 (frame_len),
    .in_data                   (in_data),
    .in_valid                  (in_valid),
    .in_ready                  (in_ready),
    .M10K_write_data_source    (wr_data),
    .M10K_write_address_source (wr_addr),
    .M10K_write_source         (wr_en),
    .START                     (start),
    .compute_done              (compute_done),
    .loaded_count              (loaded_count),
    .busy                      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] fillv(int i);
    return ~(8'(i) ^ 8'h5A);
  endfunction

  // Model of the source M10K, optionally pre-filled with a known background pattern.
  always @(posedge clk) begin
    if (tb_fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= fillv(i);
    end else if (wr_en === 1'b1) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always @(posedge clk) begin
    start_q <= start;
    if (start === 1'b1 && start_q !== 1'b1) start_rises <= start_rises + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock; a write must appear exactly in the cycle after an accepted beat.
  task automatic tick();
    logic acc;
    acc = in_valid && in_ready && !reset;
    @(posedge clk);
    #1;
    chk("wr_follows_accept", 32'(wr_en), 32'(acc));
  endtask

  task automatic fill_mem();
    tb_fill = 1'b1;
    tick();
    tb_fill = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic       go;
    logic [8:0] len;
    logic       vld;
    logic [7:0] din;
    logic       done;
    logic       e_rdy;
    logic       e_wr;
    logic [7:0] e_addr;
    logic [7:0] e_data;
    logic       e_st;
    logic       e_bsy;
    logic [8:0] e_cnt;
  } vec_t;

  vec_t vec [14];

  initial begin
    int sent;
    int cycles;
    int rises0;
    logic v;
    logic rdy;

    checks = 0; failures = 0; start_rises = 0; start_q = 1'b0; tb_fill = 1'b0;
    reset = 1'b1; load_go = 1'b0; frame_len = '0; in_data = '0; in_valid = 1'b0;
    compute_done = 1'b0;

    //           rst go   len   vld din    done rdy wr addr   data   st bsy cnt
    vec[0]  = '{1'b1, 1'b0, 9'd0,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 9'd0};
    vec[1]  = '{1'b0, 1'b1, 9'd0,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 9'd0};
    vec[2]  = '{1'b0, 1'b1, 9'd3,   1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 9'd0};
    vec[3]  = '{1'b0, 1'b0, 9'd0,   1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h00, 8'h11, 1'b0, 1'b1, 9'd1};
    vec[4]  = '{1'b0, 1'b0, 9'd0,   1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 8'h11, 1'b0, 1'b1, 9'd1};
    vec[5]  = '{1'b0, 1'b1, 9'd5,   1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h01, 8'h22, 1'b0, 1'b1, 9'd2};
    vec[6]  = '{1'b0, 1'b0, 9'd0,   1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h02, 8'h33, 1'b0, 1'b1, 9'd3};
    vec[7]  = '{1'b0, 1'b0, 9'd0,   1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 8'h02, 8'h33, 1'b1, 1'b1, 9'd3};
    vec[8]  = '{1'b0, 1'b1, 9'd2,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h02, 8'h33, 1'b1, 1'b1, 9'd3};
    vec[9]  = '{1'b0, 1'b0, 9'd0,   1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h02, 8'h33, 1'b0, 1'b0, 9'd3};
    vec[10] = '{1'b0, 1'b1, 9'd300, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h33, 1'b0, 1'b1, 9'd0};
    vec[11] = '{1'b0, 1'b0, 9'd0,   1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 8'h00, 8'h80, 1'b0, 1'b1, 9'd1};
    vec[12] = '{1'b1, 1'b0, 9'd0,   1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 9'd0};
    vec[13] = '{1'b0, 1'b0, 9'd0,   1'b1, 8'h82, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 9'd0};

    tick(); tick();

    for (int i = 0; i < 14; i++) begin
      reset = vec[i].rst; load_go = vec[i].go; frame_len = vec[i].len;
      in_valid = vec[i].vld; in_data = vec[i].din; compute_done = vec[i].done;
      tick();
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vec[i].e_rdy));
      chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vec[i].e_wr));
      chk($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(vec[i].e_addr));
      chk($sformatf("v%0d_wr_data", i), 32'(wr_data), 32'(vec[i].e_data));
      chk($sformatf("v%0d_start", i), 32'(start), 32'(vec[i].e_st));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vec[i].e_bsy));
      chk($sformatf("v%0d_count", i), 32'(loaded_count), 32'(vec[i].e_cnt));
    end
    reset = 1'b0; load_go = 1'b0; in_valid = 1'b0; compute_done = 1'b0;

    // 17-sample frame of constant 1s, START timing relative to the last accept.
    fill_mem();
    load_go = 1'b1; frame_len = 9'd17;
    tick();
    load_go = 1'b0;
    for (int k = 0; k < 17; k++) begin
      in_valid = 1'b1; in_data = 8'd1;
      tick();
    end
    in_valid = 1'b0;
    chk("f17_flush_start", 32'(start), 32'(1'b0));
    chk("f17_flush_ready", 32'(in_ready), 32'(1'b0));
    chk("f17_count", 32'(loaded_count), 32'd17);
    chk("f17_last_addr", 32'(wr_addr), 32'd16);
    tick();
    chk("f17_run_start", 32'(start), 32'(1'b1));
    for (int k = 0; k < 17; k++) chk($sformatf("f17_mem%0d", k), 32'(mem[k]), 32'd1);
    chk("f17_mem17_untouched", 32'(mem[17]), 32'(fillv(17)));
    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
    chk("f17_done_start", 32'(start), 32'(1'b0));

    // Full 256-sample frame requested with an oversize length, random valid gaps.
    fill_mem();
    load_go = 1'b1; frame_len = 9'd0;
    tick();
    chk("len0_busy", 32'(busy), 32'(1'b0));
    frame_len = 9'd300;
    tick();
    load_go = 1'b0;
    chk("len300_busy", 32'(busy), 32'(1'b1));
    chk("len300_count", 32'(loaded_count), 32'd0);
    rises0 = start_rises;
    sent = 0; cycles = 0;
    while (sent < 256 && cycles < 3000) begin
      v = ($urandom_range(0, 2) != 0);
      in_valid = v;
      in_data = v ? (8'(sent) ^ 8'h5A) : 8'hEE;
      rdy = in_ready;
      tick();
      if (v && rdy) sent++;
      cycles++;
      if (sent == 255 && v && rdy) chk("f256_pre_last_start", 32'(start), 32'(1'b0));
    end
    in_valid = 1'b0;
    chk("f256_sent_in_budget", 32'(sent), 32'd256);
    chk("f256_count", 32'(loaded_count), 32'd256);
    chk("f256_flush_ready", 32'(in_ready), 32'(1'b0));
    tick();
    chk("f256_start", 32'(start), 32'(1'b1));
    tick(); tick();
    for (int k = 0; k < 256; k++)
      chk($sformatf("f256_mem%0d", k), 32'(mem[k]), 32'(8'(k) ^ 8'h5A));
    chk("f256_start_once", 32'(start_rises - rises0), 32'd1);

    // Release and immediately reload: writes restart at address 0.
    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
    chk("rel_start", 32'(start), 32'(1'b0));
    chk("rel_busy", 32'(busy), 32'(1'b0));
    load_go = 1'b1; frame_len = 9'd2;
    tick();
    load_go = 1'b0;
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    chk("rel_wr_addr0", 32'(wr_addr), 32'd0);
    chk("rel_wr_data0", 32'(wr_data), 32'h77);
    in_data = 8'h78;
    tick();
    in_valid = 1'b0;
    chk("rel_wr_addr1", 32'(wr_addr), 32'd1);
    tick();
    chk("rel_start2", 32'(start), 32'(1'b1));
    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;

    // Reset in the middle of a 10-sample frame.
    fill_mem();
    load_go = 1'b1; frame_len = 9'd10;
    tick();
    load_go = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 8'h30 + 8'(k);
      tick();
    end
    rises0 = start_rises;
    reset = 1'b1; in_data = 8'h35;
    tick();
    chk("rst_ready", 32'(in_ready), 32'(1'b0));
    chk("rst_wr_en", 32'(wr_en), 32'(1'b0));
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_data", 32'(wr_data), 32'd0);
    chk("rst_start", 32'(start), 32'(1'b0));
    chk("rst_busy", 32'(busy), 32'(1'b0));
    chk("rst_count", 32'(loaded_count), 32'd0);
    reset = 1'b0;
    for (int k = 6; k < 11; k++) begin
      in_data = 8'h30 + 8'(k - 1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) chk($sformatf("rst_mem%0d", k), 32'(mem[k]), 32'(8'h30 + 8'(k)));
    for (int k = 5; k < 10; k++) chk($sformatf("rst_mem%0d_kept", k), 32'(mem[k]), 32'(fillv(k)));
    chk("rst_no_start", 32'(start_rises - rises0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
